// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory and the decoder.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        StClear,
        StRun,
        StLoad
    } state_e;

    // Word returned for cleared, unloaded or out-of-range locations.
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Instruction field widths shared with the decoder.
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned IMM_W    = 16;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Load port and fetch port of the instruction memory, bundled for the top-level hookup.
interface instr_mem_loadable_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) ();

    logic              load_en;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              fetch_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;

    // Program loader / fetch logic side.
    modport master (
        output load_en, load_valid, load_data, fetch_en, addr,
        input  load_ready, load_done, load_count, instr, instr_valid
    );

    // Memory side.
    modport slave (
        input  load_en, load_valid, load_data, fetch_en, addr,
        output load_ready, load_done, load_count, instr, instr_valid
    );

endinterface

// File: rtl/instr_mem_ram.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
module instr_mem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write has priority; rdata holds its last read value when idle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory: clears to NOP, loads over ready/valid, serves fetches.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input logic                 clk,
    input logic                 rst,
    instr_mem_loadable_if.slave bus
);

    localparam int unsigned     RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              use_ram_q, use_ram_d;  // instr comes from RAM rather than NOP_WORD
    logic              armed_q, armed_d;      // load_en must fall before a new LOAD may start

    logic              ram_we, ram_re;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              load_ready;
    logic              in_range;

    assign in_range = ({1'b0, bus.addr} < DEPTH_C);

    instr_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State, pointer and output-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            ptr_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            use_ram_q <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            use_ram_q <= use_ram_d;
            armed_q   <= armed_d;
        end
    end

    // Next-state logic and RAM port steering.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        use_ram_d  = use_ram_q;
        armed_d    = armed_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = ptr_q[RAM_AW-1:0];
        ram_wdata  = NOP_WORD;
        load_ready = 1'b0;

        if (!bus.load_en) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            StClear: begin
                ram_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST_C) begin
                    state_d = StRun;
                    ptr_d   = '0;
                end
            end
            StRun: begin
                if (bus.load_en && armed_q) begin
                    // Load entry wins over a same-cycle fetch, which is dropped.
                    state_d   = StLoad;
                    ptr_d     = '0;
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                    use_ram_d = 1'b0;
                end else if (bus.fetch_en) begin
                    ram_addr  = bus.addr[RAM_AW-1:0];
                    ram_re    = in_range;
                    use_ram_d = in_range;
                    valid_d   = 1'b1;
                end
            end
            StLoad: begin
                load_ready = (ptr_q < DEPTH_C);
                ram_wdata  = bus.load_data;
                if (bus.load_valid && load_ready) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (cnt_q < DEPTH_C) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (ptr_q == DEPTH_C) begin
                    // Full exit: done already pulsed; keep load_en from re-entering.
                    state_d = StRun;
                    if (bus.load_en) begin
                        armed_d = 1'b0;
                    end
                end else if (!bus.load_en) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                end else if (ram_we && (ptr_q == LAST_C)) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    assign bus.load_ready  = load_ready;
    assign bus.load_done   = done_q;
    assign bus.load_count  = cnt_q;
    assign bus.instr       = use_ram_q ? ram_rdata : NOP_WORD;
    assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable with a 200-word memory on an 8-bit address.
module tb_instr_mem_loadable;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 200;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [31:0] words [4];
    logic [31:0] k;

    instr_mem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_loadable #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
        bus.addr     = a;
        bus.fetch_en = 1'b1;
        tick();
        check_eq(tag, bus.instr, exp);
        check_eq({tag, "_valid"}, bus.instr_valid, 1'b1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        words[0]       = 32'h0F04_00FF;
        words[1]       = 32'h5081_0000;
        words[2]       = 32'h60C1_0000;
        words[3]       = 32'hB002_8000;
        rst            = 1'b1;
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.fetch_en   = 1'b0;
        bus.addr       = '0;
        tick();
        tick();
        check_eq("rst_instr", bus.instr, 32'h0);
        check_eq("rst_valid", bus.instr_valid, 1'b0);
        check_eq("rst_ready", bus.load_ready, 1'b0);
        check_eq("rst_done", bus.load_done, 1'b0);
        check_eq("rst_count", bus.load_count, 9'd0);

        // Clear phase: fetch requested throughout but ignored for DEPTH cycles.
        rst          = 1'b0;
        bus.fetch_en = 1'b1;
        repeat (DEPTH - 1) tick();
        check_eq("clear_fetch_ignored", bus.instr_valid, 1'b0);
        tick();
        check_eq("clear_last_cycle", bus.instr_valid, 1'b0);
        for (int i = 0; i < 256; i++) begin
            fetch(ADDR_W'(i), 32'h0, "cleared_word");
        end
        bus.fetch_en = 1'b0;

        // Four-word load; the last word arrives together with load_en falling.
        bus.load_en = 1'b1;
        tick();
        check_eq("load_entry_ready", bus.load_ready, 1'b1);
        check_eq("load_entry_valid", bus.instr_valid, 1'b0);
        check_eq("load_entry_instr", bus.instr, 32'h0);
        check_eq("load_entry_count", bus.load_count, 9'd0);
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            tick();
            check_eq("load4_done_low", bus.load_done, 1'b0);
        end
        bus.load_data = words[3];
        bus.load_en   = 1'b0;
        tick();
        check_eq("load4_done", bus.load_done, 1'b1);
        check_eq("load4_count", bus.load_count, 9'd4);
        check_eq("load4_fetch_ignored", bus.instr_valid, 1'b0);
        bus.load_valid = 1'b0;
        bus.fetch_en   = 1'b0;
        tick();
        check_eq("load4_done_pulse", bus.load_done, 1'b0);
        check_eq("load4_count_hold", bus.load_count, 9'd4);
        for (int i = 0; i < 4; i++) begin
            fetch(ADDR_W'(i), words[i], "load4_word");
        end
        fetch(8'd4, 32'h0, "load4_unwritten");
        bus.fetch_en = 1'b0;

        // Full-depth load with 204 words offered; source holds a word until accepted.
        bus.load_en = 1'b1;
        tick();
        k = 0;
        for (int c = 0; c < 204; c++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hA000_0000 + k;
            check_eq("full_ready", bus.load_ready, (k < DEPTH));
            check_eq("full_done", bus.load_done, (c == DEPTH));
            tick();
            if (k < DEPTH) k++;
        end
        bus.load_valid = 1'b0;
        check_eq("full_count", bus.load_count, 9'd200);
        // load_en still high: must be in RUN (fetch served) and not re-entered.
        fetch(8'd199, 32'hA000_00C7, "full_no_reentry_fetch");
        check_eq("full_no_reentry_ready", bus.load_ready, 1'b0);
        bus.fetch_en = 1'b0;
        bus.load_en  = 1'b0;
        tick();
        bus.load_en = 1'b1;
        tick();
        check_eq("rearm_ready", bus.load_ready, 1'b1);
        check_eq("rearm_count", bus.load_count, 9'd0);
        bus.load_en = 1'b0;
        tick();
        check_eq("empty_load_done", bus.load_done, 1'b1);
        check_eq("empty_load_count", bus.load_count, 9'd0);
        fetch(8'd5, 32'hA000_0005, "mem_kept");

        // Stall: fetch 2, hold during fetch_en=0 on addr 3, then fetch 4.
        fetch(8'd2, 32'hA000_0002, "stall_pre");
        bus.fetch_en = 1'b0;
        bus.addr     = 8'd3;
        tick();
        check_eq("stall_hold", bus.instr, 32'hA000_0002);
        check_eq("stall_valid", bus.instr_valid, 1'b1);
        fetch(8'd4, 32'hA000_0004, "stall_post");
        fetch(8'd250, 32'h0, "oor_250");
        fetch(8'd200, 32'h0, "oor_200");
        fetch(8'd199, 32'hA000_00C7, "last_in_range");

        // load_en beats a same-cycle fetch; then reset during a partial load.
        bus.addr    = 8'd7;
        bus.load_en = 1'b1;
        tick();
        check_eq("prio_valid", bus.instr_valid, 1'b0);
        check_eq("prio_instr", bus.instr, 32'h0);
        check_eq("prio_ready", bus.load_ready, 1'b1);
        bus.fetch_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'h1111_1111 * (i + 1);
            tick();
        end
        check_eq("partial_count", bus.load_count, 9'd2);
        rst           = 1'b1;
        bus.load_data = 32'h3333_3333;
        tick();
        check_eq("mid_rst_count", bus.load_count, 9'd0);
        check_eq("mid_rst_ready", bus.load_ready, 1'b0);
        check_eq("mid_rst_done", bus.load_done, 1'b0);
        rst            = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        repeat (DEPTH) tick();
        fetch(8'd0, 32'h0, "post_rst_w0");
        fetch(8'd1, 32'h0, "post_rst_w1");
        fetch(8'd2, 32'h0, "post_rst_w2");
        fetch(8'd150, 32'h0, "post_rst_w150");
        check_eq("post_rst_count", bus.load_count, 9'd0);
        bus.fetch_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, runtime-loadable instruction memory for the fetch stage, replacing fixed hard-wired program storage. It powers up by clearing every word to NOP, loads a program word by word over a ready/valid load port, then serves registered fetches to the PC/fetch logic. The datapath can run a new program without resynthesis.

## Interface
- DATA_W, 32, instruction width in bits
- ADDR_W, 8, fetch/load address width
- DEPTH, 256, number of words; must satisfy DEPTH ≤ 2^ADDR_W
- NOP_WORD, 0, value returned for cleared, unloaded or out-of-range words
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous and active-high
- load_en  in  1  level request to enter/stay in LOAD
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_W  program word to write
- load_ready  out  1  block accepts a load word this cycle
- load_done  out  1  one-cycle pulse when LOAD terminates
- load_count  out  ADDR_W+1  number of words written in the current or last load
- fetch_en  in  1  sample addr and update instr
- addr  in  ADDR_W  fetch address (word index)
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  instr holds a word fetched in RUN

## Operation
- States: CLEAR, RUN, LOAD.
- Reset: state ← CLEAR, clear pointer ← 0, instr ← NOP_WORD, instr_valid ← 0, load_ready ← 0, load_done ← 0, load_count ← 0.
- CLEAR: writes NOP_WORD to mem[ptr] each cycle, ptr++. After mem[DEPTH-1] is written, moves to RUN. Takes exactly DEPTH cycles. Load and fetch inputs are ignored.
- RUN: load_ready = 0.
  - fetch_en=1: instr ← mem[addr] if addr < DEPTH, else NOP_WORD; instr_valid ← 1.
  - fetch_en=0: instr and instr_valid hold (stall).
  - load_en=1: next state LOAD, write pointer ← 0, load_count ← 0, instr_valid ← 0, instr ← NOP_WORD. load_en takes priority over a same-cycle fetch_en, and that fetch is discarded.
- LOAD: load_ready = 1 while ptr < DEPTH.
  - load_valid && load_ready: mem[ptr] ← load_data, ptr++, load_count++.
  - Exit on load_en=0 or ptr reaching DEPTH: load_done pulses one cycle, state → RUN.
  - Words not written keep their previous contents; memory is not cleared between loads.
  - fetch_en is ignored; instr stays NOP_WORD and instr_valid stays 0.
- load_count saturates at DEPTH. It holds its value after load_done until the next LOAD entry or reset.

## Timing
- Fetch latency 1 cycle: addr/fetch_en sampled at edge t, instr/instr_valid valid after edge t+1. Back-to-back fetches give one word per cycle.
- Load write is visible to fetch from the cycle after RUN is re-entered. No read-during-write case exists because fetch is blocked in LOAD.
- Full boundary: the write of word DEPTH-1 occurs at edge t. load_ready is 0 from t+1; load_done is 1 for cycle t+1; state is RUN at t+2.
- load_en dropping at edge t: the load_valid word sampled at t is still written. load_done is 1 in cycle t+1.
- load_en held high after a full-depth exit: no re-entry until load_en deasserts for at least one cycle (edge-armed).
- rst in any state, including mid-LOAD or mid-CLEAR: next cycle is CLEAR with ptr 0. A partial load is discarded by the clear.
- load_valid while load_ready=0 is dropped; the source must hold the word.

## Structure
- Package instr_mem_pkg: state enum (CLEAR, RUN, LOAD), default NOP_WORD constant, opcode field widths shared with the decoder.
- Sub-module instr_mem_ram: single-port synchronous RAM (DATA_W × DEPTH, one write or one read per cycle). The top holds the FSM, pointers, out-of-range mux and output registers.

## Test plan
- Reset, then wait DEPTH=256 cycles: every addr 0..255 fetches 0x00000000 with instr_valid=1, one cycle after fetch_en.
- Load 4 words (0xF0400FF, 0x50810000, 0x60C10000, 0xB0028000), then drop load_en: load_done pulses once, load_count=4, fetches of addr 0..3 return those words, addr 4 returns 0.
- Load with DEPTH=16 and 20 words offered: load_ready drops after word 16, load_count=16, load_done pulses while load_en is still high, and there is no re-entry until load_en toggles.
- Fetch with fetch_en toggling 1,0,1 over addr 2,3,4: instr shows word 2, holds word 2 during the stall, then shows word 4.
- Assert rst after 2 of 5 load words: state returns to CLEAR, and after DEPTH cycles all words read 0 with load_count=0.
- DEPTH=200, ADDR_W=8, fetch addr 250: instr=NOP_WORD, instr_valid=1.
